// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store engine between CPU datapath and word-only memory.
// Byte/halfword/word accesses with sign/zero extension; sub-word stores are read-modify-write.
// Optional feature macro MEMACC_WSTRB_EN: adds mem_be byte strobes and turns sub-word stores
// into a single strobed write instead of read-modify-write.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef MEMACC_WSTRB_EN
    ,
    output logic [3:0]        mem_be
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e state_q, state_d;

    // Latched request attributes
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;

    // Next values of the registered outputs
    logic              busy_d, done_d, mis_d, mem_rd_d, mem_wr_d;
    logic [31:0]       rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
`ifdef MEMACC_WSTRB_EN
    logic [3:0]        be_d;
`endif

    logic [31:0] rd_shift;  // memory word with the addressed lane moved to bit 0
    logic [31:0] merged;    // memory word with the store lane replaced
    logic        bad_align;

    // Next-state, latch and registered-output computation
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_d      = sign_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata;
        mis_d       = misaligned;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
`ifdef MEMACC_WSTRB_EN
        be_d        = mem_be;
`endif

        rd_shift = mem_rdata >> {lane_q, 3'b000};
        merged   = mem_rdata;
        case (size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase

        bad_align = (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sign_d     = sign_ext;
                    lane_d     = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                    rdata_d    = '0;
                    mis_d      = bad_align;
`ifdef MEMACC_WSTRB_EN
                    be_d       = 4'b1111;
`endif
                    if (bad_align) begin
                        state_d = StDone;
`ifdef MEMACC_WSTRB_EN
                        be_d    = 4'b0000;
`endif
                    end else if (!we) begin
                        state_d = StRead;
                    end else if (size == 2'b10) begin
                        mem_wdata_d = wdata;
                        state_d     = StWrite;
                    end else begin
`ifdef MEMACC_WSTRB_EN
                        // Replicate the data and let the strobes pick the lane
                        state_d = StWrite;
                        if (size == 2'b00) begin
                            mem_wdata_d = {4{wdata[7:0]}};
                            be_d        = 4'b0001 << addr[1:0];
                        end else begin
                            mem_wdata_d = {2{wdata[15:0]}};
                            be_d        = addr[1] ? 4'b1100 : 4'b0011;
                        end
`else
                        state_d = StRead;
`endif
                    end
                end
            end
            StRead: begin
                if (mem_ack) begin
                    if (we_q) begin
                        mem_wdata_d = merged;
                        state_d     = StWrite;
                    end else begin
                        case (size_q)
                            2'b00:   rdata_d = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
                            2'b01:   rdata_d = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
                            default: rdata_d = mem_rdata;
                        endcase
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (mem_ack) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        mem_rd_d = (state_d == StRead);
        mem_wr_d = (state_d == StWrite);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
`ifdef MEMACC_WSTRB_EN
            mem_be     <= 4'b0000;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            rdata      <= rdata_d;
            misaligned <= mis_d;
            mem_addr   <= mem_addr_d;
            mem_rd     <= mem_rd_d;
            mem_wr     <= mem_wr_d;
            mem_wdata  <= mem_wdata_d;
`ifdef MEMACC_WSTRB_EN
            mem_be     <= be_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; a memory responder acks after a programmable wait.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, misaligned, mem_rd, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;
    logic [3:0]  be_seen = 4'b0000;
`ifdef MEMACC_WSTRB_EN
    logic [3:0]  mem_be;
    localparam bit Wstrb = 1'b1;
`else
    localparam bit Wstrb = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEMACC_WSTRB_EN
        , .mem_be(mem_be)
`endif
    );

    int n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0, n_issued = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after wait_n cycles of a held request
    logic [31:0] mem_word = '0, last_wd = '0, last_addr = '0;
    int  wait_n = 0, wcnt = 0, rd_cyc = 0, wr_acks = 0;
    bit  overlap = 1'b0, force_ack = 1'b0;
    assign mem_rdata = mem_word;

    always @(negedge clk) begin
        if (mem_rd && mem_wr) overlap = 1'b1;
        if (mem_rd) rd_cyc++;
        if (mem_rd || mem_wr) begin
            last_addr = mem_addr;
`ifdef MEMACC_WSTRB_EN
            be_seen = mem_be;
`endif
            if (wcnt >= wait_n) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_wr) begin
                    wr_acks++;
                    last_wd = mem_wdata;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = force_ack;
            wcnt    = 0;
        end
    end

    // Scoreboard: one entry per issued request, retired on done
    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        bit          chk_rd;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_lat"}, cyc - e.acc, e.lat);
                check({e.tag, "_mis"}, {31'b0, misaligned}, {31'b0, e.mis});
                if (e.chk_rd) check({e.tag, "_rdata"}, rdata, e.rdata);
            end
        end
    end

    task automatic issue(input string tag, input bit w, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mword,
                         input int wt, input logic [31:0] exp_rd, input bit exp_mis,
                         input bit chk_rd, input int exp_lat, input int exp_rdcyc,
                         input int exp_wr, input logic [31:0] exp_wd, input logic [3:0] exp_be,
                         input bit spur);
        exp_t e;
        int   n;
        @(negedge clk);
        mem_word = mword;
        wait_n   = wt;
        rd_cyc   = 0;
        wr_acks  = 0;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        e.tag = tag; e.rdata = exp_rd; e.mis = exp_mis; e.chk_rd = chk_rd;
        e.acc = cyc; e.lat = exp_lat;
        sb.push_back(e);
        n_issued++;
        @(negedge clk);
        req = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            // Requests raised while busy must be dropped
            if (spur && busy && !done) begin
                req  = 1'b1;
                addr = 32'h0000_0F00;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        if (n >= 40) begin
            check({tag, "_timeout"}, sb.size(), 32'd0);
            sb.delete();
        end
        #1;
        check({tag, "_rdcyc"}, rd_cyc, exp_rdcyc);
        check({tag, "_writes"}, wr_acks, exp_wr);
        if (exp_wr > 0) check({tag, "_wdata"}, last_wd, exp_wd);
        if (exp_rdcyc + exp_wr > 0) begin
            check({tag, "_maddr"}, last_addr, {a[31:2], 2'b00});
`ifdef MEMACC_WSTRB_EN
            check({tag, "_be"}, {28'b0, be_seen}, {28'b0, exp_be});
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_mis"}, {31'b0, misaligned}, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mrd"}, {31'b0, mem_rd}, 32'd0);
        check({tag, "_mwr"}, {31'b0, mem_wr}, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
`ifdef MEMACC_WSTRB_EN
        check({tag, "_be"}, {28'b0, mem_be}, 32'd0);
`endif
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        //      tag       we sz     sx addr          wdata         mem word      wt exp_rdata
        issue("ld_h_s",  0, 2'b01, 1, 32'h102, 32'h0, 32'h8001_1234, 0, 32'hFFFF_8001,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("ld_h_z",  0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_1234, 0, 32'h0000_8001,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("ld_b_7f", 0, 2'b00, 1, 32'h203, 32'h0, 32'h7F00_0000, 0, 32'h0000_007F,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("ld_b_s",  0, 2'b00, 1, 32'h201, 32'h0, 32'h0000_9C00, 0, 32'hFFFF_FF9C,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("ld_b_z",  0, 2'b00, 0, 32'h201, 32'h0, 32'h0000_9C00, 0, 32'h0000_009C,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("ld_h_lo", 0, 2'b01, 1, 32'h100, 32'h0, 32'h8001_1234, 0, 32'h0000_1234,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("ld_w",    0, 2'b10, 0, 32'h300, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);
        issue("st_b",    1, 2'b00, 0, 32'h41, 32'hAB, 32'h1122_3344, 0, 32'h0,
              0, 0, Wstrb ? 2 : 3, Wstrb ? 0 : 1, 1,
              Wstrb ? 32'hABAB_ABAB : 32'h1122_AB44, 4'b0010, 0);
        issue("st_h",    1, 2'b01, 0, 32'h12, 32'hBEEF, 32'h1122_3344, 0, 32'h0,
              0, 0, Wstrb ? 2 : 3, Wstrb ? 0 : 1, 1,
              Wstrb ? 32'hBEEF_BEEF : 32'hBEEF_3344, 4'b1100, 0);
        issue("st_w",    1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 32'h1122_3344, 0, 32'h0,
              0, 0, 2, 0, 1, 32'hCAFE_F00D, 4'b1111, 0);
        issue("mis_w",   1, 2'b10, 0, 32'h6, 32'h1234_5678, 32'h0, 0, 32'h0,
              1, 0, 1, 0, 0, 32'h0, 4'b0000, 0);
        issue("mis_h",   0, 2'b01, 1, 32'h5, 32'h0, 32'h0, 0, 32'h0,
              1, 0, 1, 0, 0, 32'h0, 4'b0000, 0);
        issue("mis_rsv", 0, 2'b11, 0, 32'h8, 32'h0, 32'h0, 0, 32'h0,
              1, 0, 1, 0, 0, 32'h0, 4'b0000, 0);
        issue("ld_wait", 0, 2'b10, 0, 32'h104, 32'h0, 32'h5566_7788, 3, 32'h5566_7788,
              0, 1, 5, 4, 0, 32'h0, 4'b1111, 0);
        issue("st_wait", 1, 2'b00, 0, 32'h43, 32'h5A, 32'h1122_3344, 2, 32'h0,
              0, 0, Wstrb ? 4 : 7, Wstrb ? 0 : 3, 1,
              Wstrb ? 32'h5A5A_5A5A : 32'h5A22_3344, 4'b1000, 0);
        issue("ld_spur", 0, 2'b10, 0, 32'h10, 32'h0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D,
              0, 1, 4, 3, 0, 32'h0, 4'b1111, 1);

        // Reset in the middle of a load: no completion, everything back to zero
        @(negedge clk);
        mem_word = 32'h1357_9BDF;
        wait_n   = 20;
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h300;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_pre_rd", {31'b0, mem_rd}, 32'd1);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid");
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt, d0);

        // Stray ack while idle must not start anything
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        check("idle_ack_busy", {31'b0, busy}, 32'd0);
        check("idle_ack_done", done_cnt, d0);

        issue("ld_after", 0, 2'b00, 0, 32'h2, 32'h0, 32'h00C3_0000, 0, 32'h0000_00C3,
              0, 1, 2, 1, 0, 32'h0, 4'b1111, 0);

        repeat (3) @(negedge clk);
        check("rd_wr_overlap", {31'b0, overlap}, 32'd0);
        check("done_count", done_cnt, n_issued);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sub-word load/store engine between the CPU datapath and the word-only data memory. It accepts one load or store per request and performs byte, halfword or word accesses with sign/zero extension. Sub-word stores run as a read-modify-write over a req/ack memory handshake. It replaces combinational halfword merging in the datapath with a sequenced, stall-driven memory transaction.

## Interface
- `ADDR_W`, 32: byte-address width on both CPU and memory sides.
- `clk  in  1`: single clock; all state changes on rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `req  in  1`: CPU request strobe; sampled only while `busy`=0.
- `we  in  1`: 1 = store, 0 = load.
- `size  in  2`: 00 byte, 01 halfword, 10 word, 11 reserved.
- `sign_ext  in  1`: loads only; 1 sign-extends, 0 zero-extends.
- `addr  in  ADDR_W`: byte address.
- `wdata  in  32`: store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy  out  1`: request in flight; CPU stalls while high.
- `done  out  1`: one-cycle completion pulse.
- `rdata  out  32`: extended load result.
- `misaligned  out  1`: error flag, valid with `done`.
- `mem_addr  out  ADDR_W`: word address, bits [1:0] always 0.
- `mem_rd  out  1`, `mem_wr  out  1`: memory read/write request levels.
- `mem_wdata  out  32`: memory write data.
- `mem_rdata  in  32`: memory read data, valid when `mem_ack`=1.
- `mem_ack  in  1`: memory completion; may be asserted in the same cycle as `mem_rd`/`mem_wr`.
- `mem_be  out  4`: byte strobes; present only with `MEMACC_WSTRB_EN`.

## Operation
- Lane mapping is little-endian. Byte n maps to bits [8n+7:8n]. Halfword at `addr[1]`=1 maps to [31:16], and at `addr[1]`=0 to [15:0].
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if `req`=1, latch `we`, `size`, `sign_ext`, `addr` and `wdata`, then branch:
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11): go to DONE with `misaligned`=1. No memory access occurs.
  - Load: go to READ.
  - Word store: go to WRITE.
  - Sub-word store: go to READ.
- READ: hold `mem_rd`=1 until `mem_ack`. On ack:
  - Load: capture the selected lane, extend it into `rdata`, go to DONE.
  - Store: merge the latched `wdata` lane into `mem_rdata`, leaving the other bytes unchanged, into `mem_wdata`, then go to WRITE.
- WRITE: hold `mem_wr`=1 with `mem_wdata` stable until `mem_ack`, then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `rdata` and `misaligned` hold their value until the next accepted request.
- `busy`=1 in READ, WRITE and DONE. A `req` while `busy` is ignored and not queued.
- `mem_rd` and `mem_wr` are never high simultaneously. `mem_addr` = {latched `addr`[ADDR_W-1:2], 2'b00}, stable throughout the transaction.

## Timing
- All outputs are registered. Reset value of every output is 0: `busy`, `done`, `rdata`, `misaligned`, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata` and `mem_be`.
- Request accepted at edge 0. `busy` and the first memory request are visible in cycle 1.
- Zero-wait latencies (`mem_ack` same cycle), measured as `done` cycle after accept:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store (RMW): 3 cycles.
  - Misaligned: 1 cycle.
- Each wait cycle of `mem_ack` adds one cycle.
- Back-to-back: a new `req` can be accepted in the cycle after `done`.
- `rst` asserted mid-transaction: the FSM returns to IDLE at the next edge and `mem_rd`/`mem_wr` drop. The memory transaction is abandoned without completion. `done` is not generated.
- A `mem_ack` received in IDLE or DONE is ignored.

## Configuration
- `MEMACC_WSTRB_EN` defined:
  - `mem_be` port exists.
  - Sub-word stores skip READ. The unit goes IDLE→WRITE with `wdata` replicated to all lanes and `mem_be` set for the target bytes only. Byte store at `addr[1:0]`=2 gives `mem_be`=4'b0100.
  - Sub-word store latency equals word store latency.
  - Loads and word stores drive `mem_be`=4'b1111.
- `MEMACC_WSTRB_EN` undefined: no `mem_be` port; sub-word stores use read-modify-write as in Operation.

## Test plan
- Load half, signed: `addr`=0x102, `mem_rdata`=0x8001_1234, `sign_ext`=1 → `rdata`=0xFFFF_8001, `done` 2 cycles after accept; with `sign_ext`=0 → 0x0000_8001.
- Load byte: `addr`=0x203, `mem_rdata`=0x7F00_0000, `sign_ext`=1 → `rdata`=0x0000_007F, `mem_addr`=0x200.
- Byte store RMW (macro off): `addr`=0x41, `wdata`=0xAB, `mem_rdata`=0x1122_3344 → one read, then a write of `mem_wdata`=0x1122_AB44, `done` at cycle 3.
- Misaligned: word store to `addr`=0x6 → `misaligned`=1 with `done` 1 cycle after accept; `mem_rd`/`mem_wr` never assert.
- Wait states and reset: `mem_ack` delayed 3 cycles → `mem_rd` held 4 cycles. In a second run, pulse `rst` while in READ → next cycle all outputs 0, no `done`.
- With `MEMACC_WSTRB_EN`: half store `addr`=0x12, `wdata`=0xBEEF → single write, `mem_be`=4'b1100, `mem_wdata[31:16]`=0xBEEF, `done` at cycle 2.
